// File: rtl/rf16b_pkg.sv
// Shared types and sizes for the 4x16-bit register-file write-back scheduler.
// Holds the register count, data width, register index type, the grant enum
// and the packed write-back payload used by the output stage.
package rf16b_pkg;

  localparam int unsigned NREGISTERS = 4;
  localparam int unsigned WIDTH      = 16;
  localparam int unsigned RIDX_W     = 2;

  typedef logic [RIDX_W-1:0] reg_idx_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  typedef struct packed {
    reg_idx_t         rd;
    logic [WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf16b_wb_sched_if.sv
// Bus bundle for the write-back scheduler.
// Groups the ALU and load-return requests, load issue, decode hazard query,
// scoreboard view and RF write port. The slave modport is the scheduler;
// the master modport is the surrounding pipeline (or a testbench).
interface rf16b_wb_sched_if;
  import rf16b_pkg::*;

  logic                  alu_valid;
  reg_idx_t              alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_ready;

  logic                  mem_valid;
  reg_idx_t              mem_rd;
  logic [WIDTH-1:0]      mem_data;
  logic                  mem_ready;

  logic                  ld_issue;
  reg_idx_t              ld_rd;
  logic                  ld_ready;

  reg_idx_t              dec_ra;
  reg_idx_t              dec_rb;
  reg_idx_t              dec_rd;
  logic                  stall;

  logic [NREGISTERS-1:0] pend;

  reg_idx_t              rf_rd;
  logic [WIDTH-1:0]      rf_data;
  logic                  rf_en;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  ld_issue, ld_rd,
    output ld_ready,
    input  dec_ra, dec_rb, dec_rd,
    output stall,
    output pend,
    output rf_rd, rf_data, rf_en
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output ld_issue, ld_rd,
    input  ld_ready,
    output dec_ra, dec_rb, dec_rd,
    input  stall,
    input  pend,
    input  rf_rd, rf_data, rf_en
  );

endinterface

// File: rtl/rf16b_scoreboard.sv
// Load scoreboard: one pending bit per register for loads in flight.
// Ports: clk, rstz (async active-low); ld_issue/ld_rd issue a load;
// mem_clr/mem_rd retire one; dec_ra/rb/rd query hazards.
// pend_o is the registered pending vector; ld_ready_c and pend_stall_c are
// combinational views of it.
module rf16b_scoreboard
  import rf16b_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstz,
  input  logic                  ld_issue,
  input  reg_idx_t              ld_rd,
  input  logic                  mem_clr,
  input  reg_idx_t              mem_rd,
  input  reg_idx_t              dec_ra,
  input  reg_idx_t              dec_rb,
  input  reg_idx_t              dec_rd,
  output logic [NREGISTERS-1:0] pend_o,
  output logic                  ld_ready_c,
  output logic                  pend_stall_c
);

  logic [NREGISTERS-1:0] pend_q;
  logic [NREGISTERS-1:0] pend_d;

  // A second load to an already-pending register is refused.
  assign ld_ready_c   = ~pend_q[ld_rd];
  assign pend_stall_c = pend_q[dec_ra] | pend_q[dec_rb] | pend_q[dec_rd];
  assign pend_o       = pend_q;

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (mem_clr) begin
      pend_d[mem_rd] = 1'b0;
    end
    if (ld_issue && ld_ready_c) begin
      pend_d[ld_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/rf16b_wb_sched.sv
// Write-back scheduler for the 4x16-bit register file.
// Arbitrates the single RF write port between the ALU result path and the
// load-return path, registers the winner into the RF write stage, and tracks
// outstanding loads to raise a decode stall on RAW/WAW hazards.
// Ports: clk, rstz (async active-low), bus (slave modport: requests, load
// issue, decode query, stall, pend, rf_rd/rf_data/rf_en), dvdd/dgnd power
// pins carrying no logic.
// Build option: RF16B_RR_ARB_EN selects round-robin arbitration; without it
// the load return always has priority and no last-grant state exists.
module rf16b_wb_sched
  import rf16b_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstz,
  rf16b_wb_sched_if.slave        bus,
  inout  wire                    dvdd,
  inout  wire                    dgnd
);

  logic [NREGISTERS-1:0] pend;
  logic                  ld_ready_c;
  logic                  pend_stall_c;

  logic                  alu_elig_c;
  logic                  alu_ready_c;
  logic                  mem_ready_c;
  logic                  alu_fire_c;
  logic                  mem_fire_c;

  wb_req_t               rf_q;
  wb_req_t               rf_d;
  logic                  rf_en_q;
  logic                  rf_en_d;

  rf16b_scoreboard u_scoreboard (
    .clk          (clk),
    .rstz         (rstz),
    .ld_issue     (bus.ld_issue),
    .ld_rd        (bus.ld_rd),
    .mem_clr      (mem_fire_c),
    .mem_rd       (bus.mem_rd),
    .dec_ra       (bus.dec_ra),
    .dec_rb       (bus.dec_rb),
    .dec_rd       (bus.dec_rd),
    .pend_o       (pend),
    .ld_ready_c   (ld_ready_c),
    .pend_stall_c (pend_stall_c)
  );

  // The ALU must not overwrite a register whose load is still in flight.
  assign alu_elig_c = bus.alu_valid & ~pend[bus.alu_rd];

`ifdef RF16B_RR_ARB_EN
  grant_e last_q;
  grant_e last_d;

  // On conflict, the requester that did not win last time goes first.
  assign mem_ready_c = ~(alu_elig_c & (last_q == GNT_MEM));
  assign alu_ready_c = alu_elig_c & ~(bus.mem_valid & (last_q == GNT_ALU));

  // Last-grant next state.
  always_comb begin
    last_d = last_q;
    if (mem_fire_c) begin
      last_d = GNT_MEM;
    end else if (alu_fire_c) begin
      last_d = GNT_ALU;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      last_q <= GNT_ALU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the load return is always accepted.
  assign mem_ready_c = 1'b1;
  assign alu_ready_c = alu_elig_c & ~bus.mem_valid;
`endif

  assign mem_fire_c = bus.mem_valid & mem_ready_c;
  assign alu_fire_c = bus.alu_valid & alu_ready_c;

  // Output stage next state; index/data hold when nothing is granted.
  always_comb begin
    rf_d    = rf_q;
    rf_en_d = mem_fire_c | alu_fire_c;
    if (mem_fire_c) begin
      rf_d.rd   = bus.mem_rd;
      rf_d.data = bus.mem_data;
    end else if (alu_fire_c) begin
      rf_d.rd   = bus.alu_rd;
      rf_d.data = bus.alu_data;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rf_q    <= '0;
      rf_en_q <= 1'b0;
    end else begin
      rf_q    <= rf_d;
      rf_en_q <= rf_en_d;
    end
  end

  assign bus.alu_ready = alu_ready_c;
  assign bus.mem_ready = mem_ready_c;
  assign bus.ld_ready  = ld_ready_c;
  assign bus.pend      = pend;
  assign bus.rf_rd     = rf_q.rd;
  assign bus.rf_data   = rf_q.data;
  assign bus.rf_en     = rf_en_q;

  // The registered write is not yet visible to RF reads, so it hazards too.
  assign bus.stall = pend_stall_c |
                     (rf_en_q & ((rf_q.rd == bus.dec_ra) |
                                 (rf_q.rd == bus.dec_rb) |
                                 (rf_q.rd == bus.dec_rd)));

endmodule

// File: tb/tb_rf16b_wb_sched.sv
// Self-checking bench for rf16b_wb_sched: directed stimulus pushes expected
// RF writes into a queue; a negedge monitor pops and compares each write.
module tb_rf16b_wb_sched;

  typedef struct {
    logic [1:0]  rd;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rstz;
  wire  dvdd;
  wire  dgnd;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  rf16b_wb_sched_if bus();

  rf16b_wb_sched dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus),
    .dvdd (dvdd),
    .dgnd (dgnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] rd, input logic [15:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    q.push_back(e);
  endtask

  // Write monitor: every RF write must match the next expected entry.
  always @(negedge clk) begin
    if (rstz && bus.rf_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h want no write", bus.rf_rd, bus.rf_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", 32'(bus.rf_rd), 32'(e.rd));
        chk("wb_data", 32'(bus.rf_data), 32'(e.data));
      end
    end
  end

  initial begin
    int  ka;
    int  km;
    logic gm;
    rstz          = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.ld_issue  = 1'b0; bus.ld_rd  = '0;
    bus.dec_ra    = '0;   bus.dec_rb = '0; bus.dec_rd   = '0;

    #2;
    chk("rst_pend", 32'(bus.pend), 32'h0);
    chk("rst_rf_en", 32'(bus.rf_en), 32'h0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'h0);
    chk("rst_rf_data", 32'(bus.rf_data), 32'h0);
    #10 rstz = 1'b1;
    tick();

    // Single ALU write, 1-cycle latency.
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd2; bus.alu_data = 16'h1234;
    #1 chk("alu_ready_first", 32'(bus.alu_ready), 32'h1);
    push(2'd2, 16'h1234);
    tick();
    bus.alu_valid = 1'b0;
    #1 chk("first_rf_en", 32'(bus.rf_en), 32'h1);
    chk("first_rf_rd", 32'(bus.rf_rd), 32'h2);
    chk("first_rf_data", 32'(bus.rf_data), 32'h1234);
    tick();
    chk("first_rf_en_drop", 32'(bus.rf_en), 32'h0);

    // Conflict: mem wins (also in round-robin, since last grant was ALU).
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd1; bus.alu_data = 16'hAAAA;
    bus.mem_valid = 1'b1; bus.mem_rd = 2'd3; bus.mem_data = 16'h5555;
    #1 chk("conf_mem_ready", 32'(bus.mem_ready), 32'h1);
    chk("conf_alu_ready", 32'(bus.alu_ready), 32'h0);
    push(2'd3, 16'h5555);
    tick();
    bus.mem_valid = 1'b0;
    #1 chk("conf_alu_ready2", 32'(bus.alu_ready), 32'h1);
    chk("conf_rf_rd_mem", 32'(bus.rf_rd), 32'h3);
    push(2'd1, 16'hAAAA);
    tick();
    bus.alu_valid = 1'b0;
    chk("conf_rf_rd_alu", 32'(bus.rf_rd), 32'h1);
    chk("conf_rf_data_alu", 32'(bus.rf_data), 32'hAAAA);

    // Both valid for four cycles.
    ka = 0;
    km = 0;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 2'd1; bus.alu_data = 16'(32'hA000 + ka);
      bus.mem_valid = 1'b1; bus.mem_rd = 2'd3; bus.mem_data = 16'(32'hB000 + km);
      #1;
`ifdef RF16B_RR_ARB_EN
      gm = ((i % 2) == 0);
`else
      gm = 1'b1;
`endif
      chk("both_mem_ready", 32'(bus.mem_ready), 32'(gm));
      chk("both_alu_ready", 32'(bus.alu_ready), 32'(!gm));
      if (gm) begin
        push(2'd3, 16'(32'hB000 + km));
        km++;
      end else begin
        push(2'd1, 16'(32'hA000 + ka));
        ka++;
      end
      tick();
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    tick();
    tick();

    // Scoreboard: pending load blocks decode and ALU write to that register.
    bus.ld_issue = 1'b1; bus.ld_rd = 2'd0;
    #1 chk("ld_ready_free", 32'(bus.ld_ready), 32'h1);
    tick();
    bus.ld_issue = 1'b0;
    #1 chk("pend_set0", 32'(bus.pend), 32'h1);
    bus.dec_ra = 2'd0; bus.dec_rb = 2'd1; bus.dec_rd = 2'd1;
    #1 chk("stall_pend", 32'(bus.stall), 32'h1);
    bus.dec_ra = 2'd1;
    #1 chk("stall_clear", 32'(bus.stall), 32'h0);
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd0; bus.alu_data = 16'hDEAD;
    #1 chk("alu_waw_block", 32'(bus.alu_ready), 32'h0);
    bus.alu_valid = 1'b0;
    bus.ld_issue = 1'b1; bus.ld_rd = 2'd0;
    #1 chk("ld_ready_busy", 32'(bus.ld_ready), 32'h0);
    tick();
    bus.ld_issue = 1'b0;
    #1 chk("pend_unchanged", 32'(bus.pend), 32'h1);
    bus.mem_valid = 1'b1; bus.mem_rd = 2'd0; bus.mem_data = 16'hC0DE;
    #1 chk("mem_ready_ret", 32'(bus.mem_ready), 32'h1);
    push(2'd0, 16'hC0DE);
    tick();
    bus.mem_valid = 1'b0;
    bus.dec_ra = 2'd0;
    #1 chk("pend_cleared", 32'(bus.pend), 32'h0);
    chk("stall_wb", 32'(bus.stall), 32'h1);
    tick();
    chk("stall_wb_done", 32'(bus.stall), 32'h0);

    // Same-cycle set/clear on register 2.
    bus.ld_issue = 1'b1; bus.ld_rd = 2'd2;
    tick();
    bus.ld_issue = 1'b0;
    #1 chk("pend_set2", 32'(bus.pend), 32'h4);
    bus.mem_valid = 1'b1; bus.mem_rd = 2'd2; bus.mem_data = 16'h2222;
    bus.ld_issue = 1'b1; bus.ld_rd = 2'd2;
    #1 chk("same_ld_ready_busy", 32'(bus.ld_ready), 32'h0);
    push(2'd2, 16'h2222);
    tick();
    bus.mem_valid = 1'b0; bus.ld_issue = 1'b0;
    #1 chk("same_pend_cleared", 32'(bus.pend), 32'h0);
    bus.mem_valid = 1'b1; bus.mem_rd = 2'd2; bus.mem_data = 16'h3333;
    bus.ld_issue = 1'b1; bus.ld_rd = 2'd2;
    #1 chk("same_ld_ready_free", 32'(bus.ld_ready), 32'h1);
    push(2'd2, 16'h3333);
    tick();
    bus.mem_valid = 1'b0; bus.ld_issue = 1'b0;
    #1 chk("same_set_wins", 32'(bus.pend), 32'h4);

    // Build pend=1010 with a write in the output stage, then reset mid-cycle.
    bus.mem_valid = 1'b1; bus.mem_rd = 2'd2; bus.mem_data = 16'h4444;
    push(2'd2, 16'h4444);
    tick();
    bus.mem_valid = 1'b0;
    bus.ld_issue = 1'b1; bus.ld_rd = 2'd1;
    tick();
    bus.ld_rd = 2'd3;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd0; bus.alu_data = 16'h5555;
    #1 chk("pre_rst_alu_ready", 32'(bus.alu_ready), 32'h1);
    push(2'd0, 16'h5555);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_rst_rf_en", 32'(bus.rf_en), 32'h1);
    chk("pre_rst_pend", 32'(bus.pend), 32'hA);
    rstz = 1'b0;
    #1;
    chk("async_rst_rf_en", 32'(bus.rf_en), 32'h0);
    chk("async_rst_pend", 32'(bus.pend), 32'h0);
    chk("async_rst_rf_rd", 32'(bus.rf_rd), 32'h0);
    chk("async_rst_rf_data", 32'(bus.rf_data), 32'h0);
    #5 rstz = 1'b1;
    tick();
    tick();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf16b_wb_sched.md
Name: rf16b_wb_sched

Overview:
Write-back scheduler and load scoreboard for the 4x16-bit register file. Shares the single RF write port between two requesters:
- ALU result path.
- Memory load-return path.

It also tracks registers with outstanding loads and raises a decode stall on RAW/WAW hazards. Sits between execute/memory stages and the RF `rd`/`data`/`en` inputs.

Parameters:
NREGISTERS, 4, number of architectural registers (RAW index width = 2)
WIDTH, 16, data width

Ports:
clk  input  1  rising-edge clock
rstz  input  1  asynchronous active-low reset
alu_valid  input  1  ALU write-back request
alu_rd  input  2  ALU destination register
alu_data  input  WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load-return write-back request
mem_rd  input  2  load destination register
mem_data  input  WIDTH  load data
mem_ready  output  1  load return accepted this cycle
ld_issue  input  1  load issued to memory this cycle
ld_rd  input  2  destination of issued load
ld_ready  output  1  ld_rd may be issued (not already pending)
dec_ra  input  2  decode source A
dec_rb  input  2  decode source B
dec_rd  input  2  decode destination
stall  output  1  decode must hold
pend  output  NREGISTERS  scoreboard bits, 1 = load outstanding
rf_rd  output  2  RF write index
rf_data  output  WIDTH  RF write data
rf_en  output  1  RF write enable
dvdd  inout  1  power pin, no logic
dgnd  inout  1  ground pin, no logic

Behaviour:
- Reset (rstz low, asynchronous): pend=0, rf_en=0, rf_rd=0, rf_data=0, last_grant=ALU. Combinational outputs follow from these values. Reset mid-transaction drops any accepted-but-unwritten result and clears all pending loads.
- Eligibility:
  - alu_elig = alu_valid & !pend[alu_rd]. The ALU may never overwrite a register with an outstanding load (WAW).
  - mem_elig = mem_valid.
- Arbitration (default, fixed priority): mem wins. mem_ready=1; alu_ready = alu_elig & !mem_valid.
- Exactly one grant per cycle. A transfer occurs on valid&ready.
- Output stage is a single register with 1-cycle latency:
  - The granted request loads rf_rd/rf_data and sets rf_en=1 on the next edge.
  - With no grant, rf_en=0 next cycle; rf_rd/rf_data hold.
  - The RF commits at the following edge. No backpressure from the RF.
- Scoreboard:
  - ld_ready = !pend[ld_rd].
  - ld_issue&ld_ready sets pend[ld_rd].
  - ld_issue while pend[ld_rd]=1 is ignored and leaves pend unchanged.
  - Accepted mem write clears pend[mem_rd]. This applies even if the bit was clear, which is benign.
  - Same register set and cleared in one cycle: set wins.
- Stall, combinational:
  - stall=1 if pend[dec_ra] | pend[dec_rb] | pend[dec_rd].
  - stall=1 if rf_en & rf_rd ∈ {dec_ra, dec_rb, dec_rd}. The write is not yet visible to RF reads.
- alu_ready/mem_ready depend combinationally on valids; requesters must not make valid depend on ready.
- Requester rules: valid, rd and data must stay stable until accepted. Dropping valid before acceptance is allowed; the request is then lost, with no error.

Optional Feature:
RF16B_RR_ARB_EN:
- Defined: round-robin replaces fixed priority.
  - On conflict (alu_elig & mem_valid), grant the requester not equal to last_grant.
  - last_grant updates on every grant.
  - mem_ready = !(alu_elig & last_grant==MEM); alu_ready = alu_elig & !(mem_valid & last_grant==ALU).
- Undefined: fixed mem-first; last_grant register absent.

Decomposition:
- Package rf16b_pkg holds:
  - NREGISTERS, WIDTH, register index type (2 bits).
  - Grant enum {GNT_ALU, GNT_MEM}.
- One sub-module, rf16b_scoreboard, contains the pend vector, set/clear priority, ld_ready and the pend-based part of stall. The arbiter and output stage stay in the top.

Test Plan:
- Reset, then release rstz: pend=0000, rf_en=0, rf_rd=0, rf_data=0; alu_valid=1 alu_rd=2 alu_data=0x1234 -> alu_ready=1; next cycle rf_en=1 rf_rd=2 rf_data=0x1234; following cycle rf_en=0.
- Conflict, fixed mode: alu(rd=1,0xAAAA) and mem(rd=3,0x5555) same cycle -> mem granted, rf_rd=3 rf_data=0x5555; ALU held, written next cycle (rf_rd=1 rf_data=0xAAAA).
- Conflict, RR_ARB_EN, both valid for 4 cycles -> grants alternate MEM, ALU, MEM, ALU starting from reset last_grant=ALU.
- Scoreboard: ld_issue ld_rd=0 -> pend=0001; dec_ra=0 -> stall=1; alu_rd=0 alu_valid=1 -> alu_ready=0; second ld_issue ld_rd=0 -> ld_ready=0, pend unchanged; mem return rd=0 -> pend=0000, then stall=1 for one cycle (rf_en&rf_rd=0), then stall=0.
- Same-cycle: pend[2]=1, mem return rd=2 with ld_issue ld_rd=2 -> ld_ready=0, issue ignored, pend[2]=0; repeat with pend[2]=0 -> pend[2]=1 (set wins).
- Async reset asserted mid-cycle with rf_en=1 and pend=1010 -> rf_en=0 and pend=0000 immediately, before the next clock edge.
